// File: rtl/demux_1t16_reg_nb.sv
// demux_1t16_reg_nb: registered 1-to-16 write demultiplexer.
// A write strobe steers DIN into one of 16 holding registers selected by SEL.
// Each destination carries a pending flag that stays set until its consumer
// acknowledges it. An overwrite of unacknowledged data raises a one-cycle ERR.
// Every output comes straight from a flop, so no input reaches an output
// without passing through a register.
// Optional feature, macro DEMUX_READBACK_EN: adds RD_SEL/RD_DATA, a registered
// readback of the holding registers with no write-through.

module demux_1t16_reg_nb #(
  parameter int n = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         WE,
  input  logic [3:0]   SEL,
  input  logic [n-1:0] DIN,
  input  logic [15:0]  ACK,
`ifdef DEMUX_READBACK_EN
  input  logic [3:0]   RD_SEL,
`endif
  output logic [n-1:0] Q0,
  output logic [n-1:0] Q1,
  output logic [n-1:0] Q2,
  output logic [n-1:0] Q3,
  output logic [n-1:0] Q4,
  output logic [n-1:0] Q5,
  output logic [n-1:0] Q6,
  output logic [n-1:0] Q7,
  output logic [n-1:0] Q8,
  output logic [n-1:0] Q9,
  output logic [n-1:0] Q10,
  output logic [n-1:0] Q11,
  output logic [n-1:0] Q12,
  output logic [n-1:0] Q13,
  output logic [n-1:0] Q14,
  output logic [n-1:0] Q15,
  output logic [15:0]  UPD,
  output logic [15:0]  PEND,
  output logic         ERR
`ifdef DEMUX_READBACK_EN
  ,
  output logic [n-1:0] RD_DATA
`endif
);

  logic [n-1:0] r_q [16];
  logic [15:0]  r_upd;
  logic [15:0]  r_pend;
  logic         r_err;
  logic [15:0]  w_set;

  // One-hot mask of the destination being written this cycle, empty when idle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_set = '0;
    if (WE) w_set = 16'b1 << SEL;
  end

  // Holding registers: only the selected destination loads; the others hold.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      // NOTE: the holding registers are architecturally visible and must read 0 after reset, so this small array is reset explicitly.
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
    end else if (WE) begin
      r_q[SEL] <= DIN;
    end
  end

  // Update pulse lines up with the cycle in which the new Q value appears.
  always_ff @(posedge CLK) begin
    if (RST) r_upd <= '0;
    else     r_upd <= w_set;
  end

  // Pending flags: a write sets the flag and wins over a same-cycle ACK,
  // because that ACK refers to the data being replaced.
  always_ff @(posedge CLK) begin
    if (RST) r_pend <= '0;
    else     r_pend <= w_set | (r_pend & ~ACK);
  end

  // Overwrite error: a write to a still-pending destination that is not
  // being acknowledged in the same cycle. The pulse is not sticky.
  always_ff @(posedge CLK) begin
    if (RST) r_err <= 1'b0;
    else     r_err <= WE && r_pend[SEL] && !ACK[SEL];
  end

`ifdef DEMUX_READBACK_EN
  logic [n-1:0] r_rd_data;

  // Readback samples the pre-write contents, so a same-cycle write is not forwarded.
  always_ff @(posedge CLK) begin
    if (RST) r_rd_data <= '0;
    else     r_rd_data <= r_q[RD_SEL];
  end

  assign RD_DATA = r_rd_data;
`endif

  assign Q0   = r_q[0];
  assign Q1   = r_q[1];
  assign Q2   = r_q[2];
  assign Q3   = r_q[3];
  assign Q4   = r_q[4];
  assign Q5   = r_q[5];
  assign Q6   = r_q[6];
  assign Q7   = r_q[7];
  assign Q8   = r_q[8];
  assign Q9   = r_q[9];
  assign Q10  = r_q[10];
  assign Q11  = r_q[11];
  assign Q12  = r_q[12];
  assign Q13  = r_q[13];
  assign Q14  = r_q[14];
  assign Q15  = r_q[15];
  assign UPD  = r_upd;
  assign PEND = r_pend;
  assign ERR  = r_err;

endmodule
